// File: rtl/checkout_pkg.sv
// rtl/checkout_pkg.sv - shared types and UPC helpers for the checkout marker
package checkout_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PAY,
        MARK,
        DONE,
        ABORT
    } state_t;

    // UPC is {u,p,c}; must match the exit detector's discount equation
    function automatic logic is_discount(input logic [2:0] upc);
        return upc[1] | (upc[2] & upc[0]);
    endfunction

    function automatic logic is_valid_upc(input logic [2:0] upc, input logic [7:0] mask);
        return mask[upc];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for sale statistics
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/checkout_marker.sv
// rtl/checkout_marker.sv - checkout station: capture item, await payment, request mark
module checkout_marker
    import checkout_pkg::*;
#(
    parameter int          PAY_TIMEOUT    = 16,
    parameter logic [7:0]  VALID_UPC_MASK = 8'b0110_1011,
    parameter int          CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       upc,
    input  logic             item_valid,
    output logic             item_ready,
    input  logic             pay_ok,
    input  logic             cancel,
    output logic             mark_req,
    input  logic             mark_ack,
    output logic             discounted,
    output logic             sale_done,
    output logic             abort,
    output logic [CNT_W-1:0] sold_cnt,
    output logic [CNT_W-1:0] disc_cnt
);

    localparam int             TMR_W    = (PAY_TIMEOUT > 2) ? $clog2(PAY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PAY_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             disc_q, disc_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        disc_d  = disc_q;
        case (state_q)
            IDLE: begin
                disc_d = 1'b0;
                if (item_valid) begin
                    disc_d  = is_discount(upc);
                    timer_d = '0;
                    state_d = is_valid_upc(upc, VALID_UPC_MASK) ? WAIT_PAY : ABORT;
                end
            end
            WAIT_PAY: begin
                timer_d = timer_q + TMR_W'(1);
                // cancel outranks a same-cycle payment
                if (cancel) begin
                    state_d = ABORT;
                end else if (pay_ok) begin
                    state_d = MARK;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ABORT;
                end
            end
            MARK: begin
                if (mark_ack) begin
                    state_d = DONE;
                end
            end
            DONE, ABORT: begin
                state_d = IDLE;
                disc_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                disc_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            disc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            disc_q  <= disc_d;
        end
    end

    assign item_ready = (state_q == IDLE);
    assign mark_req   = (state_q == MARK);
    assign sale_done  = (state_q == DONE);
    assign abort      = (state_q == ABORT);
    assign discounted = disc_q;

    sat_counter #(.CNT_W(CNT_W)) u_sold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (state_q == DONE),
        .count   (sold_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_disc_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     ((state_q == DONE) && disc_q),
        .count   (disc_cnt)
    );

endmodule

// File: tb/tb_checkout_marker.sv
// tb/tb_checkout_marker.sv - self-checking bench for checkout_marker
module tb_checkout_marker;
    import checkout_pkg::*;

    localparam int PAY_TIMEOUT = 16;
    localparam int CNT_W       = 8;
    localparam int CMAX        = 255;
    localparam int NCYC        = 8192;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       upc = 3'b000;
    logic             item_valid = 1'b0;
    logic             item_ready;
    logic             pay_ok = 1'b0;
    logic             cancel = 1'b0;
    logic             mark_req;
    logic             mark_ack = 1'b0;
    logic             discounted;
    logic             sale_done;
    logic             abort;
    logic [CNT_W-1:0] sold_cnt;
    logic [CNT_W-1:0] disc_cnt;

    checkout_marker #(
        .PAY_TIMEOUT    (PAY_TIMEOUT),
        .VALID_UPC_MASK (8'b0110_1011),
        .CNT_W          (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .upc        (upc),
        .item_valid (item_valid),
        .item_ready (item_ready),
        .pay_ok     (pay_ok),
        .cancel     (cancel),
        .mark_req   (mark_req),
        .mark_ack   (mark_ack),
        .discounted (discounted),
        .sale_done  (sale_done),
        .abort      (abort),
        .sold_cnt   (sold_cnt),
        .disc_cnt   (disc_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected timeline, indexed by cycle; zero means idle behaviour
    bit busy_e [NCYC];
    bit mark_e [NCYC];
    bit done_e [NCYC];
    bit abort_e[NCYC];
    bit disc_e [NCYC];
    bit inc_s  [NCYC];
    bit inc_d  [NCYC];

    int m_sold = 0;
    int m_disc = 0;
    int mark_hi = 0;
    int abort_hi = 0;
    int last_abort_cyc = -1;
    bit last_done_disc = 1'b0;
    int last_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            m_sold = 0;
            m_disc = 0;
        end else if (cyc < NCYC) begin
            chk("item_ready", 32'(item_ready), 32'(!busy_e[cyc]));
            chk("mark_req",   32'(mark_req),   32'(mark_e[cyc]));
            chk("sale_done",  32'(sale_done),  32'(done_e[cyc]));
            chk("abort",      32'(abort),      32'(abort_e[cyc]));
            chk("discounted", 32'(discounted), 32'(disc_e[cyc]));
            chk("sold_cnt",   32'(sold_cnt),   32'(m_sold));
            chk("disc_cnt",   32'(disc_cnt),   32'(m_disc));
            if (mark_req) mark_hi++;
            if (abort) begin
                abort_hi++;
                last_abort_cyc = cyc;
            end
            if (sale_done) last_done_disc = discounted;
            if (inc_s[cyc]) m_sold = (m_sold < CMAX) ? m_sold + 1 : CMAX;
            if (inc_d[cyc]) m_disc = (m_disc < CMAX) ? m_disc + 1 : CMAX;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Paid sale: pay_ok pd cycles after acceptance, mark_ack ad cycles after mark_req rises
    task automatic do_sale(input logic [2:0] code, input int pd, input int ad, input bit cancel_mark);
        int n, p, a;
        n = cyc; p = n + pd; a = p + 1 + ad;
        last_n = n;
        for (int k = n + 1; k <= a + 1; k++) begin
            busy_e[k] = 1'b1;
            disc_e[k] = is_discount(code);
        end
        for (int k = p + 1; k <= a; k++) mark_e[k] = 1'b1;
        done_e[a+1] = 1'b1;
        inc_s[a+1]  = 1'b1;
        inc_d[a+1]  = is_discount(code);
        upc = code; item_valid = 1'b1;
        step();
        item_valid = 1'b0;
        while (cyc < p) step();
        pay_ok = 1'b1;
        step();
        pay_ok = 1'b0;
        if (cancel_mark) cancel = 1'b1;
        while (cyc < a) step();
        mark_ack = 1'b1;
        step();
        mark_ack = 1'b0;
        cancel = 1'b0;
        step();
    endtask

    // kind 0: undefined code, 1: payment timeout, 2: pay_ok+cancel together t cycles after accept
    task automatic do_abort(input logic [2:0] code, input int kind, input int t);
        int n, ab;
        n = cyc;
        last_n = n;
        ab = (kind == 0) ? n + 1 : (kind == 1) ? n + PAY_TIMEOUT + 1 : n + t + 1;
        for (int k = n + 1; k <= ab; k++) begin
            busy_e[k] = 1'b1;
            disc_e[k] = is_discount(code);
        end
        abort_e[ab] = 1'b1;
        upc = code; item_valid = 1'b1;
        step();
        item_valid = 1'b0;
        if (kind == 2) begin
            while (cyc < n + t) step();
            pay_ok = 1'b1; cancel = 1'b1;
            step();
            pay_ok = 1'b0; cancel = 1'b0;
        end
        while (cyc < ab + 1) step();
    endtask

    initial begin
        int m0, a0, n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst item_ready", 32'(item_ready), 32'd1);
        chk("rst mark_req",   32'(mark_req),   32'd0);
        chk("rst abort",      32'(abort),      32'd0);
        chk("rst sold_cnt",   32'(sold_cnt),   32'd0);
        reset_n = 1'b1;
        step(); step();

        m0 = mark_hi;
        do_sale(3'b011, 1, 2, 1'b0);
        chk("sale1 mark cycles", 32'(mark_hi - m0), 32'd3);
        chk("sale1 disc", 32'(last_done_disc), 32'd1);
        chk("sale1 sold", 32'(sold_cnt), 32'd1);
        chk("sale1 dcnt", 32'(disc_cnt), 32'd1);

        pay_ok = 1'b1; mark_ack = 1'b1;
        step();
        pay_ok = 1'b0; mark_ack = 1'b0;
        step();

        do_sale(3'b000, 1, 1, 1'b0);
        chk("sale2 disc", 32'(last_done_disc), 32'd0);
        chk("sale2 sold", 32'(sold_cnt), 32'd2);
        chk("sale2 dcnt", 32'(disc_cnt), 32'd1);

        m0 = mark_hi; a0 = abort_hi;
        do_abort(3'b010, 0, 0);
        chk("undef abort offset", 32'(last_abort_cyc - last_n), 32'd1);
        chk("undef abort count", 32'(abort_hi - a0), 32'd1);
        chk("undef no mark", 32'(mark_hi - m0), 32'd0);
        chk("undef sold", 32'(sold_cnt), 32'd2);

        m0 = mark_hi;
        do_abort(3'b001, 1, 0);
        chk("timeout abort offset", 32'(last_abort_cyc - last_n), 32'd17);
        chk("timeout no mark", 32'(mark_hi - m0), 32'd0);

        m0 = mark_hi;
        do_abort(3'b101, 2, 3);
        chk("cancel+pay offset", 32'(last_abort_cyc - last_n), 32'd4);
        chk("cancel+pay no mark", 32'(mark_hi - m0), 32'd0);

        do_sale(3'b110, 2, 3, 1'b1);
        chk("cancel-in-mark sold", 32'(sold_cnt), 32'd3);
        chk("cancel-in-mark dcnt", 32'(disc_cnt), 32'd2);

        for (int i = 0; i < 260; i++) do_sale(3'b011, 1, 0, 1'b0);
        chk("sat sold", 32'(sold_cnt), 32'd255);
        chk("sat dcnt", 32'(disc_cnt), 32'd255);

        // Reset in the middle of MARK
        n = cyc;
        busy_e[n+1] = 1'b1; disc_e[n+1] = 1'b1;
        busy_e[n+2] = 1'b1; disc_e[n+2] = 1'b1; mark_e[n+2] = 1'b1;
        upc = 3'b011; item_valid = 1'b1;
        step();
        item_valid = 1'b0; pay_ok = 1'b1;
        step();
        pay_ok = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("mid rst mark_req", 32'(mark_req), 32'd0);
        chk("mid rst item_ready", 32'(item_ready), 32'd1);
        chk("mid rst sold", 32'(sold_cnt), 32'd0);
        chk("mid rst dcnt", 32'(disc_cnt), 32'd0);
        chk("mid rst abort", 32'(abort), 32'd0);
        step();
        reset_n = 1'b1;
        a0 = abort_hi;
        repeat (3) step();
        chk("post rst no abort", 32'(abort_hi - a0), 32'd0);

        do_sale(3'b101, 1, 0, 1'b0);
        chk("post rst sold", 32'(sold_cnt), 32'd1);
        chk("post rst dcnt", 32'(disc_cnt), 32'd1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
